// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser and the future frame-transmit block.
// Holds the parser state encoding, drop-cause codes and the length check.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_EMIT    = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic logic len_valid(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload storage for one frame: DEPTH x 8 registers, synchronous write, combinational read.
// Address decode is done per entry so the address may be one bit wider than the depth needs.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we_i && (waddr_i == AW'(i))) begin
        mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_i == AW'(i)) begin
        rdata_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC/LEN/payload/CSUM frames from a UART byte stream, buffers the payload
// and replays it on a valid/ready stream once the checksum has been confirmed.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic [7:0] s_data_i,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic [7:0] m_data_o,
  output logic       m_last_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q,     state_d;
  logic [LW-1:0] len_q,       len_d;
  logic [LW-1:0] wr_idx_q,    wr_idx_d;
  logic [LW-1:0] rd_idx_q,    rd_idx_d;
  logic [7:0]    csum_q,      csum_d;
  logic [TW-1:0] tmo_q,       tmo_d;
  logic          frame_ok_q,  frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q,  err_code_d;

  logic       in_fire;
  logic       out_fire;
  logic       counting;
  logic       tmo_hit;
  logic       buf_we;
  logic [7:0] buf_rdata;

  assign in_fire  = s_valid_i && s_ready_o;
  assign out_fire = m_valid_o && m_ready_i;
  assign counting = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  assign tmo_hit  = !in_fire && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q),
    .wdata_i (s_data_i),
    .raddr_i (rd_idx_q),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    csum_d      = csum_q;
    tmo_d       = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    if (counting) begin
      tmo_d = in_fire ? '0 : tmo_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (in_fire && (s_data_i == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (in_fire) begin
          if (len_valid(s_data_i, MAX_LEN)) begin
            len_d    = LW'(s_data_i);
            csum_d   = s_data_i;
            wr_idx_d = '0;
            state_d  = ST_PAYLOAD;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BAD_LEN;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_fire) begin
          buf_we   = 1'b1;
          csum_d   = csum_q ^ s_data_i;
          wr_idx_d = wr_idx_q + LW'(1);
          if (wr_idx_q == len_q - LW'(1)) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (in_fire) begin
          if (s_data_i == csum_q) begin
            rd_idx_d = '0;
            state_d  = ST_EMIT;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        if (out_fire) begin
          if (rd_idx_q == len_q - LW'(1)) begin
            frame_ok_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + LW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An accepted byte clears tmo_hit, so a byte on the deadline cycle always wins.
    if (counting && tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      tmo_d       = '0;
      state_d     = ST_IDLE;
    end
  end

  always_comb begin
    s_ready_o   = (state_q != ST_EMIT);
    m_valid_o   = (state_q == ST_EMIT);
    m_data_o    = buf_rdata;
    m_last_o    = (state_q == ST_EMIT) && (rd_idx_q == len_q - LW'(1));
    frame_ok_o  = frame_ok_q;
    frame_err_o = frame_err_q;
    err_code_o  = err_code_q;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: expected events are queued as frames are sent
// and a negedge monitor pops and compares them as the DUT produces beats and pulses.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  // Short timeout keeps the run small; the deadline arithmetic is the same as at 100000.
  localparam int TIMEOUT = 1000;

  localparam int K_BEAT = 0;
  localparam int K_OK   = 1;
  localparam int K_ERR  = 2;

  logic       clk_i;
  logic       rst_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] s_data_i;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [7:0] m_data_o;
  logic       m_last_o;
  logic       frame_ok_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       last;
    logic [1:0] code;
  } exp_item_t;

  exp_item_t exp_q[$];

  int check_count = 0;
  int error_count = 0;

  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  logic       stall_last = 1'b0;

  uart_frame_parser #(
    .MAX_LEN        (MAX_LEN),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .frame_ok_o  (frame_ok_o),
    .frame_err_o (frame_err_o),
    .err_code_o  (err_code_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_beat(input logic [7:0] data, input logic last);
    exp_item_t e;
    e.kind = K_BEAT; e.data = data; e.last = last; e.code = 2'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_ok();
    exp_item_t e;
    e.kind = K_OK; e.data = 8'h00; e.last = 1'b0; e.code = 2'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_item_t e;
    e.kind = K_ERR; e.data = 8'h00; e.last = 1'b0; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic expect_event(input int kind);
    exp_item_t e;
    if (exp_q.size() == 0) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL unexpected_event: got kind %0d, expected nothing", kind);
      return;
    end
    e = exp_q.pop_front();
    checkOutput("event_kind", kind, e.kind);
    if (kind == K_BEAT && e.kind == K_BEAT) begin
      checkOutput("beat_data", m_data_o, e.data);
      checkOutput("beat_last", m_last_o, e.last);
    end
    if (kind == K_ERR && e.kind == K_ERR) begin
      checkOutput("err_code", err_code_o, e.code);
    end
  endtask

  // Drive one byte and hold it until the DUT accepts it; returns 1 time unit after the accept edge.
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    s_valid_i = 1'b1;
    s_data_i  = b;
    @(negedge clk_i);
    while (!s_ready_o && waited < 2000) begin
      @(negedge clk_i);
      waited++;
    end
    if (!s_ready_o) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL byte_accept: got s_ready_o=0 for 2000 cycles, expected 1");
    end
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk_i);
      n++;
    end
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (stall_prev && m_valid_o) begin
        checkOutput("stall_data_stable", m_data_o, stall_data);
        checkOutput("stall_last_stable", m_last_o, stall_last);
      end
      if (m_valid_o && m_ready_i) expect_event(K_BEAT);
      if (frame_ok_o)             expect_event(K_OK);
      if (frame_err_o)            expect_event(K_ERR);
      if (frame_ok_o || frame_err_o) checkOutput("ok_err_exclusive", frame_ok_o & frame_err_o, 0);
    end
    stall_prev = m_valid_o && !m_ready_i;
    stall_data = m_data_o;
    stall_last = m_last_o;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    m_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_s_ready", s_ready_o, 1);
    checkOutput("rst_m_valid", m_valid_o, 0);
    checkOutput("rst_m_last", m_last_o, 0);
    checkOutput("rst_frame_ok", frame_ok_o, 0);
    checkOutput("rst_frame_err", frame_err_o, 0);
    checkOutput("rst_err_code", err_code_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    $display("[TB] three-byte frame, downstream always ready");
    push_beat(8'h11, 0); push_beat(8'h22, 0); push_beat(8'h33, 1); push_ok();
    applyStimulus(8'hA5); applyStimulus(8'h03);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    applyStimulus(8'h03);
    @(negedge clk_i);
    checkOutput("valid_after_csum", m_valid_o, 1);
    checkOutput("first_beat_data", m_data_o, 8'h11);
    wait_drain(20);

    $display("[TB] leading junk discarded, single-byte frame");
    push_beat(8'h5A, 1); push_ok();
    applyStimulus(8'h00); applyStimulus(8'h7F);
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h5A); applyStimulus(8'h5B);
    wait_drain(20);

    $display("[TB] checksum mismatch");
    push_err(2'd2);
    applyStimulus(8'hA5); applyStimulus(8'h02);
    applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h00);
    wait_drain(20);

    $display("[TB] length too large, then zero, then a good frame");
    push_err(2'd1);
    applyStimulus(8'hA5); applyStimulus(8'h11);
    wait_drain(20);
    push_err(2'd1);
    applyStimulus(8'hA5); applyStimulus(8'h00);
    wait_drain(20);
    push_beat(8'hC3, 0); push_beat(8'h3C, 1); push_ok();
    applyStimulus(8'hA5); applyStimulus(8'h02);
    applyStimulus(8'hC3); applyStimulus(8'h3C); applyStimulus(8'hFD);
    wait_drain(20);

    $display("[TB] maximum length frame");
    for (int i = 0; i < MAX_LEN; i++) push_beat(8'(i), (i == MAX_LEN - 1));
    push_ok();
    applyStimulus(8'hA5); applyStimulus(8'h10);
    for (int i = 0; i < MAX_LEN; i++) applyStimulus(8'(i));
    applyStimulus(8'h10);
    wait_drain(40);

    $display("[TB] sync value inside length and payload is plain data");
    push_beat(8'hA5, 0); push_beat(8'h01, 1); push_ok();
    applyStimulus(8'hA5); applyStimulus(8'h02);
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'hA6);
    wait_drain(20);

    $display("[TB] inter-byte timeout");
    push_err(2'd3);
    applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'hAA);
    wait_drain(TIMEOUT + 20);
    checkOutput("s_ready_after_timeout", s_ready_o, 1);

    $display("[TB] byte on the deadline cycle prevents timeout");
    push_beat(8'hAA, 0); push_beat(8'hBB, 1); push_ok();
    applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'hAA);
    repeat (TIMEOUT - 1) @(posedge clk_i);
    #1;
    applyStimulus(8'hBB);
    applyStimulus(8'h13);
    wait_drain(20);
    checkOutput("err_code_held", err_code_o, 3);

    $display("[TB] four-byte frame with random downstream stalls");
    push_beat(8'h01, 0); push_beat(8'h02, 0); push_beat(8'h03, 0); push_beat(8'h04, 1); push_ok();
    m_ready_i = 1'b0;
    applyStimulus(8'hA5); applyStimulus(8'h04);
    applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
    applyStimulus(8'h00);
    @(negedge clk_i);
    checkOutput("s_ready_in_emit", s_ready_o, 0);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      m_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk_i);
      #1;
    end
    m_ready_i = 1'b1;
    wait_drain(20);

    $display("[TB] reset while emitting");
    m_ready_i = 1'b0;
    applyStimulus(8'hA5); applyStimulus(8'h02);
    applyStimulus(8'h77); applyStimulus(8'h88); applyStimulus(8'hFD);
    @(negedge clk_i);
    checkOutput("emit_before_reset", m_valid_o, 1);
    checkOutput("emit_data_before_reset", m_data_o, 8'h77);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_reset_m_valid", m_valid_o, 0);
    checkOutput("post_reset_s_ready", s_ready_o, 1);
    checkOutput("post_reset_err_code", err_code_o, 0);
    m_ready_i = 1'b1;
    wait_drain(10);

    $display("[TB] recovery frame after reset");
    push_beat(8'hA5, 1); push_ok();
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'hA5); applyStimulus(8'hA4);
    wait_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
